// File: rtl/blk_4dd263_if.sv
// blk_4dd263_if: Avalon-ST beat-in / symbol-out stream bundle for the 32-to-8 width adapter
interface blk_4dd263_if #(parameter int DATA_W = 32, ERROR_W = 6, EMPTY_W = 2, SYMBOL_W = 8);
  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_data;
  logic [ERROR_W-1:0]  in_error;
  logic                in_startofpacket;
  logic                in_endofpacket;
  logic [EMPTY_W-1:0]  in_empty;
  logic                out_ready;
  logic                out_valid;
  logic [SYMBOL_W-1:0] out_data;
  logic [ERROR_W-1:0]  out_error;
  logic                out_startofpacket;
  logic                out_endofpacket;
  modport slave (
    input  in_valid, in_data, in_error, in_startofpacket, in_endofpacket, in_empty, out_ready,
    output in_ready, out_valid, out_data, out_error, out_startofpacket, out_endofpacket
  );
  modport master (
    output in_valid, in_data, in_error, in_startofpacket, in_endofpacket, in_empty, out_ready,
    input  in_ready, out_valid, out_data, out_error, out_startofpacket, out_endofpacket
  );
endinterface

// File: rtl/blk_4dd263.sv
// blk_4dd263: Avalon-ST width adapter, 4-symbol beats in, one symbol per beat out, empty symbols dropped.
// Define SOPC_ST_WIDTH_ADAPTER_PKT_CHECK_EN to add the pkt_err sop/eop framing check output.
module blk_4dd263 #(
  parameter int IN_SYMBOLS = 4,
  parameter int SYMBOL_W   = 8,
  parameter int ERROR_W    = 6,
  parameter int MSB_FIRST  = 1
) (
  input  logic clk,
  input  logic reset,
  blk_4dd263_if.slave bus
`ifdef SOPC_ST_WIDTH_ADAPTER_PKT_CHECK_EN
  , output logic pkt_err
`endif
);
  localparam int DW = IN_SYMBOLS * SYMBOL_W;
  localparam int IW = $clog2(IN_SYMBOLS);
  localparam int NW = IW + 1;
  logic          full_q, full_d, sop_q, sop_d, eop_q, eop_d;
  logic [DW-1:0] data_q, data_d;
  logic [ERROR_W-1:0] err_q, err_d;
  logic [NW-1:0] n_q, n_d;
  logic [IW-1:0] idx_q, idx_d, sel;
  logic          last, take, rdy, acc;
  always_comb begin
    last   = {1'b0, idx_q} == n_q - NW'(1);
    take   = full_q & bus.out_ready;
    rdy    = !full_q | (take & last);
    acc    = bus.in_valid & rdy;
    full_d = acc | (full_q & !(take & last));
    idx_d  = acc ? '0 : take ? idx_q + IW'(1) : idx_q;
    data_d = acc ? bus.in_data : data_q;
    err_d  = acc ? bus.in_error : err_q;
    sop_d  = acc ? bus.in_startofpacket : sop_q;
    eop_d  = acc ? bus.in_endofpacket : eop_q;
    n_d    = !acc ? n_q : bus.in_endofpacket ? NW'(IN_SYMBOLS) - {1'b0, bus.in_empty} : NW'(IN_SYMBOLS);
    sel    = MSB_FIRST != 0 ? IW'(IN_SYMBOLS - 1) - idx_q : idx_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      full_q <= 1'b0;
      data_q <= '0;
      err_q  <= '0;
      sop_q  <= 1'b0;
      eop_q  <= 1'b0;
      n_q    <= '0;
      idx_q  <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      err_q  <= err_d;
      sop_q  <= sop_d;
      eop_q  <= eop_d;
      n_q    <= n_d;
      idx_q  <= idx_d;
    end
  // Last symbol out and next beat in share a cycle, so in_ready looks through to out_ready.
  assign bus.in_ready          = rdy;
  assign bus.out_valid         = full_q;
  assign bus.out_data          = data_q[sel*SYMBOL_W +: SYMBOL_W];
  assign bus.out_error         = err_q;
  assign bus.out_startofpacket = full_q & sop_q & (idx_q == '0);
  assign bus.out_endofpacket   = full_q & eop_q & last;
`ifdef SOPC_ST_WIDTH_ADAPTER_PKT_CHECK_EN
  logic open_q, open_d, perr_q, perr_d;
  always_comb begin
    perr_d = acc & (bus.in_startofpacket == open_q);
    open_d = !acc ? open_q : bus.in_endofpacket ? 1'b0 : bus.in_startofpacket | open_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      open_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      open_q <= open_d;
      perr_q <= perr_d;
    end
  assign pkt_err = perr_q;
`endif
endmodule

// File: tb/tb_blk_4dd263.sv
// tb_blk_4dd263: scoreboard bench for the 32-to-8 width adapter; expected symbols are queued at issue.
module tb_blk_4dd263;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  blk_4dd263_if bus ();
`ifdef SOPC_ST_WIDTH_ADAPTER_PKT_CHECK_EN
  logic pkt_err;
  blk_4dd263 dut (.clk(clk), .reset(reset), .bus(bus), .pkt_err(pkt_err));
`else
  blk_4dd263 dut (.clk(clk), .reset(reset), .bus(bus));
`endif
  typedef struct packed {
    logic [7:0] d;
    logic [5:0] e;
    logic       s;
    logic       p;
    logic       l;
  } sym_t;
  sym_t exp_q[$];
  int   take_q[$];
  int   errors = 0, checks = 0, cyc = 0, mode = 0;
  logic        hold_v = 1'b0;
  logic [15:0] hold_val;
  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  // mode 0: always ready, 1: toggle every clock, 2: stalled
  always @(posedge clk) begin
    #1;
    bus.out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ~bus.out_ready : 1'b0;
  end
  always @(negedge clk) begin : monitor
    sym_t e;
    if (reset) hold_v = 1'b0;
    else begin
      if (hold_v && bus.out_valid)
        chk("hold_stable", {bus.out_data, bus.out_error, bus.out_startofpacket, bus.out_endofpacket}, hold_val);
      hold_v = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_symbol: got %h expected none", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          chk("symbol", {bus.out_data, bus.out_error, bus.out_startofpacket, bus.out_endofpacket},
              {e.d, e.e, e.s, e.p});
          if (e.l) chk("in_ready_last", bus.in_ready, 1);
          take_q.push_back(cyc);
        end
      end else if (bus.out_valid) begin
        hold_v   = 1'b1;
        hold_val = {bus.out_data, bus.out_error, bus.out_startofpacket, bus.out_endofpacket};
      end
    end
  end
  task automatic send(logic [31:0] d, logic [5:0] e, logic s, logic p, logic [1:0] em);
    int   n = p ? 4 - em : 4;
    bit   ok = 0;
    sym_t x;
    for (int k = 0; k < n; k++) begin
      x.d = d[31-8*k -: 8];
      x.e = e;
      x.s = s && k == 0;
      x.p = p && k == n - 1;
      x.l = k == n - 1;
      exp_q.push_back(x);
    end
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.in_error = e;
    bus.in_startofpacket = s;
    bus.in_endofpacket = p;
    bus.in_empty = em;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 clks");
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0 && !bus.out_valid) break;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_error = '0;
    bus.in_startofpacket = 1'b0;
    bus.in_endofpacket = 1'b0;
    bus.in_empty = '0;
    #12;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_error", bus.out_error, 0);
    chk("rst_sop_eop", {bus.out_startofpacket, bus.out_endofpacket}, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 chk("in_ready_after_reset", bus.in_ready, 1);
    take_q.delete();
    send(32'hAABBCCDD, 6'h05, 1, 0, 0);
    drain();
    chk("t1_count", take_q.size(), 4);
    chk("t1_span", take_q[3] - take_q[0], 3);
    take_q.delete();
    send(32'h01020304, 6'h11, 0, 0, 0);
    send(32'h05060708, 6'h12, 0, 1, 2);
    drain();
    chk("t2_count", take_q.size(), 6);
    chk("t2_no_bubble", take_q[5] - take_q[0], 5);
    take_q.delete();
    mode = 1;
    send(32'h1A2B3C4D, 6'h2A, 1, 0, 0);
    drain();
    chk("t3_count", take_q.size(), 4);
    chk("t3_span", take_q[3] - take_q[0], 6);
    mode = 0;
    @(posedge clk);
    #1 send(32'h11223344, 6'h2A, 1, 1, 3);
    drain();
    send(32'hCAFEBABE, 6'h01, 1, 0, 0);
    @(posedge clk);
    #2 mode = 2;
    @(posedge clk);
    #4;
    chk("t5_pre_valid", bus.out_valid, 1);
    chk("t5_idx2_data", bus.out_data, 8'hBA);
    reset = 1'b1;
    #1;
    chk("t5_async_valid", bus.out_valid, 0);
    chk("t5_async_data", bus.out_data, 0);
    chk("t5_async_sop_eop", {bus.out_startofpacket, bus.out_endofpacket}, 0);
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    mode = 0;
    send(32'h55667788, 6'h03, 1, 1, 0);
    drain();
`ifdef SOPC_ST_WIDTH_ADAPTER_PKT_CHECK_EN
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("t6_rst_pkt_err", pkt_err, 0);
    send(32'h01010101, 6'h00, 0, 0, 0);
    chk("t6_nosop_err", pkt_err, 1);
    @(posedge clk);
    #1 chk("t6_pulse_one_clk", pkt_err, 0);
    send(32'h02020202, 6'h00, 1, 0, 0);
    chk("t6_sop_ok", pkt_err, 0);
    send(32'h03030303, 6'h00, 1, 0, 0);
    chk("t6_double_sop_err", pkt_err, 1);
    drain();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
